// File: rtl/fpmult_operand_sequencer.sv
// Operand sequencer for a serial-operand FP32 multiplier.
// Accepts an operand pair, sends A then B on one bus, returns the product.
//
// Ports:
//   clock, nreset          clock and synchronous active-low reset
//   in_valid/in_ready      operand pair handshake (in_a, in_b)
//   mul_a                  registered shared operand bus to the multiplier
//   mul_product/mul_ready  multiplier result and its valid strobe
//   out_valid/out_ready    result handshake (out_product, out_timeout)
module fpmult_operand_sequencer #(
   parameter int unsigned A_CYCLES   = 2,
   parameter int unsigned TIMEOUT    = 16,
   parameter int unsigned GAP_CYCLES = 1
) (
   input  logic        clock,
   input  logic        nreset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   output logic [31:0] mul_a,
   input  logic [31:0] mul_product,
   input  logic        mul_ready,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_product,
   output logic        out_timeout
);

   localparam int unsigned M1 =
      (A_CYCLES > TIMEOUT) ? A_CYCLES : TIMEOUT;
   localparam int unsigned CMAX =
      (M1 > GAP_CYCLES) ? M1 : GAP_CYCLES;
   localparam int unsigned CW = $clog2(CMAX + 1);

   localparam logic [CW-1:0] A_LAST  = CW'(A_CYCLES - 1);
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
   // GAP is unreachable when GAP_CYCLES is zero
   localparam logic [CW-1:0] GAP_LAST =
      (GAP_CYCLES == 0) ? '0 : CW'(GAP_CYCLES - 1);

   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   typedef enum logic [2:0] {
      IDLE,
      SEND_A,
      SEND_B,
      HOLD,
      GAP
   } state_t;

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic [31:0]   a_q;
   logic [31:0]   b_q;
   logic [31:0]   mul_a_q;
   logic          out_valid_q;
   logic [31:0]   out_product_q;
   logic          out_timeout_q;

   assign in_ready    = nreset && (state_q == IDLE);
   assign mul_a       = mul_a_q;
   assign out_valid   = out_valid_q;
   assign out_product = out_product_q;
   assign out_timeout = out_timeout_q;

   // mul_a is loaded alongside each transition so the bus is
   // already correct in the first cycle of the new state.
   always_ff @(posedge clock) begin
      if (!nreset) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         a_q           <= '0;
         b_q           <= '0;
         mul_a_q       <= '0;
         out_valid_q   <= 1'b0;
         out_product_q <= '0;
         out_timeout_q <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               mul_a_q <= '0;
               if (in_valid) begin
                  a_q     <= in_a;
                  b_q     <= in_b;
                  mul_a_q <= in_a;
                  cnt_q   <= '0;
                  state_q <= SEND_A;
               end
            end
            SEND_A: begin
               if (cnt_q == A_LAST) begin
                  mul_a_q <= b_q;
                  cnt_q   <= '0;
                  state_q <= SEND_B;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            SEND_B: begin
               // a real result beats the timeout on the same edge
               if (mul_ready) begin
                  out_product_q <= mul_product;
                  out_timeout_q <= 1'b0;
                  out_valid_q   <= 1'b1;
                  mul_a_q       <= '0;
                  cnt_q         <= '0;
                  state_q       <= HOLD;
               end else if (cnt_q == TO_LAST) begin
                  out_product_q <= QNAN;
                  out_timeout_q <= 1'b1;
                  out_valid_q   <= 1'b1;
                  mul_a_q       <= '0;
                  cnt_q         <= '0;
                  state_q       <= HOLD;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            HOLD: begin
               mul_a_q <= '0;
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  cnt_q       <= '0;
                  state_q     <= (GAP_CYCLES == 0) ? IDLE : GAP;
               end
            end
            GAP: begin
               mul_a_q <= '0;
               if (cnt_q == GAP_LAST) begin
                  cnt_q   <= '0;
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
               mul_a_q <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fpmult_operand_sequencer.sv
// Self-checking bench for fpmult_operand_sequencer.
// Directed vector table, reset corner cases, then random jobs.
module tb_fpmult_operand_sequencer;

   localparam int A_C = 2;
   localparam int TO  = 16;
   localparam int GAP = 1;
   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   logic        clock = 1'b0;
   logic        nreset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic [31:0] mul_a;
   logic [31:0] mul_product;
   logic        mul_ready;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_product;
   logic        out_timeout;

   always #5 clock = ~clock;

   fpmult_operand_sequencer #(
      .A_CYCLES  (A_C),
      .TIMEOUT   (TO),
      .GAP_CYCLES(GAP)
   ) dut (
      .clock      (clock),
      .nreset     (nreset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .mul_a      (mul_a),
      .mul_product(mul_product),
      .mul_ready  (mul_ready),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_product(out_product),
      .out_timeout(out_timeout)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      int          k;      // SEND_B edge carrying mul_ready, 0 = never
      logic [31:0] prod;
      int          hold;   // cycles of out_ready=0 in HOLD
      logic [31:0] exp_p;
      logic        exp_to;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %08h want %08h", nm, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Timeline model: accept edge E0, SEND_B entered at E0+A_C,
   // result captured at SEND_B edge c = k if 1<=k<=TO, else TO.
   task automatic run_job(input logic [31:0] a, input logic [31:0] b,
                          input int k, input logic [31:0] prod,
                          input int hold, input logic [31:0] exp_p,
                          input logic exp_to);
      int c;
      int sb;
      c = (k >= 1 && k <= TO) ? k : TO;
      chk("idle_in_ready", 32'(in_ready), 32'd1);
      in_valid    = 1'b1;
      in_a        = a;
      in_b        = b;
      mul_ready   = 1'($urandom_range(0, 1));
      mul_product = $urandom;
      step();
      in_valid = 1'b0;
      in_a     = $urandom;
      in_b     = $urandom;
      for (int p = 0; p < A_C + c; p++) begin
         chk("busy_in_ready", 32'(in_ready), 32'd0);
         chk("busy_out_valid", 32'(out_valid), 32'd0);
         if (p < A_C) chk("mul_a_opA", mul_a, a);
         else         chk("mul_a_opB", mul_a, b);
         sb = p + 1 - A_C;
         if (sb <= 0) begin
            mul_ready   = 1'($urandom_range(0, 1));
            mul_product = $urandom;
         end else if (sb == k) begin
            mul_ready   = 1'b1;
            mul_product = prod;
         end else begin
            mul_ready   = 1'b0;
            mul_product = $urandom;
         end
         step();
      end
      for (int h = 0; h <= hold; h++) begin
         chk("res_valid", 32'(out_valid), 32'd1);
         chk("res_product", out_product, exp_p);
         chk("res_timeout", 32'(out_timeout), 32'(exp_to));
         chk("hold_mul_a", mul_a, 32'd0);
         chk("hold_in_ready", 32'(in_ready), 32'd0);
         out_ready   = (h == hold);
         mul_ready   = 1'($urandom_range(0, 1));
         mul_product = 32'hDEADBEEF;
         step();
      end
      out_ready = 1'b0;
      for (int g = 0; g < GAP; g++) begin
         chk("gap_out_valid", 32'(out_valid), 32'd0);
         chk("gap_mul_a", mul_a, 32'd0);
         chk("gap_in_ready", 32'(in_ready), 32'd0);
         mul_ready   = 1'($urandom_range(0, 1));
         mul_product = $urandom;
         step();
      end
      mul_ready = 1'b0;
      chk("reidle_in_ready", 32'(in_ready), 32'd1);
      chk("reidle_out_valid", 32'(out_valid), 32'd0);
      chk("reidle_mul_a", mul_a, 32'd0);
   endtask

   initial begin
      vecs[0] = '{32'h4F861C46, 32'h4FA3E9AC, 3, 32'h3D8F5C28, 0,
                  32'h3D8F5C28, 1'b0};
      vecs[1] = '{32'h12345678, 32'h9ABCDEF0, 0, 32'h11111111, 0,
                  32'h7FC00000, 1'b1};
      vecs[2] = '{32'h4F861C46, 32'h4FA3E9AC, 3, 32'h3D8F5C28, 5,
                  32'h3D8F5C28, 1'b0};
      vecs[3] = '{32'h40000000, 32'hC0400000, 16, 32'h3F800000, 1,
                  32'h3F800000, 1'b0};
      vecs[4] = '{32'h7F800000, 32'h00000000, 1, 32'hFFC00001, 2,
                  32'hFFC00001, 1'b0};

      nreset      = 1'b0;
      in_valid    = 1'b0;
      in_a        = '0;
      in_b        = '0;
      mul_ready   = 1'b0;
      mul_product = '0;
      out_ready   = 1'b0;

      // reset values with random inputs
      for (int i = 0; i < 2; i++) begin
         in_valid    = 1'($urandom_range(0, 1));
         in_a        = $urandom;
         in_b        = $urandom;
         mul_ready   = 1'($urandom_range(0, 1));
         mul_product = $urandom;
         out_ready   = 1'($urandom_range(0, 1));
         step();
         chk("rst_mul_a", mul_a, 32'd0);
         chk("rst_out_valid", 32'(out_valid), 32'd0);
         chk("rst_out_product", out_product, 32'd0);
         chk("rst_out_timeout", 32'(out_timeout), 32'd0);
         chk("rst_in_ready", 32'(in_ready), 32'd0);
      end
      nreset    = 1'b1;
      in_valid  = 1'b0;
      mul_ready = 1'b0;
      out_ready = 1'b0;
      step();
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);

      foreach (vecs[i])
         run_job(vecs[i].a, vecs[i].b, vecs[i].k, vecs[i].prod,
                 vecs[i].hold, vecs[i].exp_p, vecs[i].exp_to);

      // reset during SEND_B aborts the job
      in_valid = 1'b1;
      in_a     = 32'hAAAA5555;
      in_b     = 32'h5555AAAA;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < A_C; i++) step();
      chk("mid_mul_a_opB", mul_a, 32'h5555AAAA);
      nreset = 1'b0;
      step();
      chk("mid_rst_mul_a", mul_a, 32'd0);
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
      nreset = 1'b1;
      for (int i = 0; i < TO + 4; i++) begin
         mul_ready   = 1'($urandom_range(0, 1));
         mul_product = $urandom;
         step();
         chk("aborted_out_valid", 32'(out_valid), 32'd0);
         chk("aborted_out_product", out_product, 32'd0);
         chk("aborted_mul_a", mul_a, 32'd0);
      end
      mul_ready = 1'b0;
      run_job(32'h3F800000, 32'h40490FDB, 2, 32'h40490FDB, 0,
              32'h40490FDB, 1'b0);

      // random jobs against the timeline model
      for (int n = 0; n < 40; n++) begin
         logic [31:0] ra;
         logic [31:0] rb;
         logic [31:0] rp;
         int          rk;
         int          rh;
         ra = $urandom;
         rb = $urandom;
         rp = $urandom;
         rk = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, TO + 3));
         rh = int'($urandom_range(0, 3));
         run_job(ra, rb, rk, rp, rh,
                 (rk >= 1 && rk <= TO) ? rp : QNAN,
                 !(rk >= 1 && rk <= TO));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
